// File: rtl/tc0100scn_rom_server.sv
// TC0100SCN tile-ROM toggle-handshake responder: fetches 32-bit words as two 16-bit SDRAM reads.
// Define TC0100SCN_ROM_CACHE_EN to add a one-entry word cache that answers repeat addresses without memory.
module tc0100scn_rom_server #(
    parameter int ADDR_W   = 21,
    parameter int DEADLINE = 28
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rom_address,
    input  logic              rom_req,
    output logic              rom_ack,
    output logic [31:0]       rom_data,
    output logic [ADDR_W-2:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data,
    output logic [7:0]        late_cnt,
    output logic              busy
);
    localparam int         WA_W    = ADDR_W - 2;
    localparam logic [7:0] LATE_AT = 8'(DEADLINE - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t state;

    logic            req_seen;
    logic            pending;
    logic [WA_W-1:0] lat_addr;
    logic [WA_W-1:0] fetch_addr;
    logic            fetch_tag;
    logic [15:0]     lo_word;
    logic [7:0]      timer;
    logic            detect;
    logic            hit;
    logic            fetch_done;
    logic            unused_addr_lsb;

    assign detect          = rom_req != req_seen;
    assign busy            = state != IDLE;
    assign fetch_done      = (state == HI) && mem_ack;
    assign unused_addr_lsb = ^rom_address[1:0];

`ifdef TC0100SCN_ROM_CACHE_EN
    logic [WA_W-1:0] tag_addr;
    logic            tag_valid;
    logic            hit_pend;
    logic            hit_tag;

    // Only answer from the cache when nothing is queued or in flight, so acks stay in order.
    assign hit = detect && tag_valid && (rom_address[ADDR_W-1:2] == tag_addr)
                 && (state == IDLE) && !pending && !hit_pend;
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rom_ack    <= 1'b0;
            rom_data   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            late_cnt   <= '0;
            req_seen   <= 1'b0;
            pending    <= 1'b0;
            lat_addr   <= '0;
            fetch_addr <= '0;
            fetch_tag  <= 1'b0;
            lo_word    <= '0;
            timer      <= '0;
`ifdef TC0100SCN_ROM_CACHE_EN
            tag_addr   <= '0;
            tag_valid  <= 1'b0;
            hit_pend   <= 1'b0;
            hit_tag    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (pending) begin
                        state      <= LO;
                        mem_req    <= 1'b1;
                        mem_addr   <= {lat_addr, 1'b0};
                        fetch_addr <= lat_addr;
                        fetch_tag  <= req_seen;
                        timer      <= '0;
                        pending    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                LO: begin
                    if (mem_ack) begin
                        lo_word  <= mem_data;
                        mem_addr <= {fetch_addr, 1'b1};
                        state    <= HI;
                    end
                end
                HI: begin
                    if (mem_ack) begin
                        rom_data <= {mem_data, lo_word};
                        rom_ack  <= fetch_tag;
                        mem_req  <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase

            // The timer passes LATE_AT once per fetch, so a late fetch is counted exactly once.
            if ((state == LO || state == HI) && !fetch_done) begin
                if (timer != 8'hFF) timer <= timer + 8'd1;
                if (timer == LATE_AT && late_cnt != 8'hFF) late_cnt <= late_cnt + 8'd1;
            end

            // Placed after the FSM so a toggle in the start cycle re-arms pending.
            if (detect) begin
                req_seen <= rom_req;
                lat_addr <= rom_address[ADDR_W-1:2];
                if (!hit) pending <= 1'b1;
            end

`ifdef TC0100SCN_ROM_CACHE_EN
            if (fetch_done) begin
                tag_addr  <= fetch_addr;
                tag_valid <= 1'b1;
            end
            hit_pend <= hit;
            if (hit) hit_tag <= rom_req;
            if (hit_pend) rom_ack <= hit_tag;
`endif
        end
    end

endmodule

// File: tb/tb_tc0100scn_rom_server.sv
// Directed bench for tc0100scn_rom_server: latency, deadline, supersede, reset, cache and saturation.
`timescale 1ns/1ps
module tb_tc0100scn_rom_server;
    localparam int ADDR_W = 21;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] rom_address = '0;
    logic              rom_req = 1'b0;
    logic              rom_ack;
    logic [31:0]       rom_data;
    logic [ADDR_W-2:0] mem_addr;
    logic              mem_req;
    logic              mem_ack = 1'b0;
    logic [15:0]       mem_data = '0;
    logic [7:0]        late_cnt;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int mem_delay = 0;
    int wcnt = 0;
    int log_n = 0;
    int ack_changes = 0;
    int n, t0, b0;
    logic force_ack = 1'b0;
    logic [ADDR_W-2:0] log_addr [16];

    tc0100scn_rom_server #(.ADDR_W(ADDR_W), .DEADLINE(28)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rom_address(rom_address),
        .rom_req    (rom_req),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .late_cnt   (late_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [ADDR_W-2:0] a);
        case (a)
            20'h00082: return 16'h1234;
            20'h00083: return 16'hABCD;
            default:   return 16'(a[15:0] * 16'd37 + 16'h0101);
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [ADDR_W-1:0] a);
        return {mem_word({a[ADDR_W-1:2], 1'b1}), mem_word({a[ADDR_W-1:2], 1'b0})};
    endfunction

    // SDRAM channel model: acks after mem_delay waiting cycles per word, logs word addresses.
    always @(negedge clk) begin
        if (mem_ack) wcnt = 0;
        mem_ack = 1'b0;
        if (force_ack) begin
            mem_ack  = 1'b1;
            mem_data = 16'hDEAD;
        end else if (mem_req) begin
            if (wcnt >= mem_delay) begin
                mem_ack  = 1'b1;
                mem_data = mem_word(mem_addr);
                log_addr[log_n % 16] = mem_addr;
                log_n++;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(rom_ack) ack_changes++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic toggle(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        rom_address = a;
        rom_req     = ~rom_req;
    endtask

    task automatic wait_ack(input string tag, input int bound, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (rom_ack !== rom_req && cyc < bound);
        chk({tag, "_ack"}, 32'(rom_ack), 32'(rom_req));
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",      32'(rom_ack),  32'd0);
        chk("rst_data",     rom_data,      32'd0);
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_late",     32'(late_cnt), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        @(negedge clk) reset_n = 1'b1;

        // 1) zero-wait fetch, minimum latency
        mem_delay = 0;
        b0 = log_n;
        toggle(21'h000104);
        wait_ack("t1", 20, n);
        chk("t1_latency", 32'(n), 32'd4);
        chk("t1_data",    rom_data, 32'hABCD1234);
        chk("t1_lo_addr", 32'(log_addr[b0 % 16]), 32'h82);
        chk("t1_hi_addr", 32'(log_addr[(b0 + 1) % 16]), 32'h83);
        chk("t1_late",    32'(late_cnt), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_idle", 32'(busy), 32'd0);

        // 2) slow memory misses the deadline once
        mem_delay = 20;
        t0 = ack_changes;
        toggle(21'h000200);
        wait_ack("t2", 100, n);
        chk("t2_data", rom_data, exp_word(21'h000200));
        chk("t2_late", 32'(late_cnt), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t2_toggles", 32'(ack_changes - t0), 32'd1);

        // 3) two toggles during fetch A collapse to one fetch of C
        mem_delay = 6;
        t0 = ack_changes;
        b0 = log_n;
        toggle(21'h000400);
        repeat (3) @(negedge clk);
        toggle(21'h000500);
        repeat (2) @(negedge clk);
        toggle(21'h000604);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (ack_changes == t0 && n < 100);
        chk("t3_a_addr", 32'(log_addr[b0 % 16]), 32'h200);
        chk("t3_a_data", rom_data, exp_word(21'h000400));
        chk("t3_a_ack",  32'(rom_ack), 32'd1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (log_n - b0 < 4 && n < 100);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_reads",      32'(log_n - b0), 32'd4);
        chk("t3_c_lo",       32'(log_addr[(b0 + 2) % 16]), 32'h302);
        chk("t3_c_hi",       32'(log_addr[(b0 + 3) % 16]), 32'h303);
        chk("t3_c_data",     rom_data, exp_word(21'h000604));
        chk("t3_ack_eq_req", 32'(rom_ack), 32'(rom_req));
        chk("t3_toggles",    32'(ack_changes - t0), 32'd1);

        // 4) reset during HI wait, then a stray mem_ack
        mem_delay = 4;
        toggle(21'h000300);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(mem_req && mem_addr[0]) && n < 50);
        chk("t4_in_hi", 32'(mem_req & mem_addr[0]), 32'd1);
        @(negedge clk);
        reset_n   = 1'b0;
        rom_req   = 1'b0;
        mem_delay = 1000;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_rst_ack",      32'(rom_ack),  32'd0);
        chk("t4_rst_data",     rom_data,      32'd0);
        chk("t4_rst_mem_req",  32'(mem_req),  32'd0);
        chk("t4_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("t4_rst_late",     32'(late_cnt), 32'd0);
        chk("t4_rst_busy",     32'(busy),     32'd0);
        @(negedge clk) reset_n = 1'b1;
        t0 = ack_changes;
        @(posedge clk);
        #2 force_ack = 1'b1;
        @(posedge clk);
        #2 force_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t4_stray_ack",     32'(rom_ack), 32'd0);
        chk("t4_stray_data",    rom_data,     32'd0);
        chk("t4_stray_busy",    32'(busy),    32'd0);
        chk("t4_stray_mem_req", 32'(mem_req), 32'd0);
        chk("t4_stray_toggles", 32'(ack_changes - t0), 32'd0);

        // 5) repeat of the same address
        mem_delay = 0;
        toggle(21'h000104);
        wait_ack("t5_fill", 20, n);
        chk("t5_fill_data", rom_data, 32'hABCD1234);
        repeat (2) @(posedge clk);
        b0 = log_n;
        toggle(21'h000104);
        wait_ack("t5_rep", 20, n);
`ifdef TC0100SCN_ROM_CACHE_EN
        chk("t5_hit_latency", 32'(n), 32'd2);
        chk("t5_hit_reads",   32'(log_n - b0), 32'd0);
`else
        chk("t5_rep_latency", 32'(n), 32'd4);
        chk("t5_rep_reads",   32'(log_n - b0), 32'd2);
        chk("t5_rep_lo_addr", 32'(log_addr[b0 % 16]), 32'h82);
`endif
        chk("t5_rep_data", rom_data, 32'hABCD1234);

        // 6) 300 late fetches saturate late_cnt
        mem_delay = 15;
        for (int i = 0; i < 300; i++) begin
            toggle(21'h010000 + 21'(i * 4));
            wait_ack("t6", 200, n);
            if (i == 99) chk("t6_late_100", 32'(late_cnt), 32'd100);
        end
        chk("t6_late_sat", 32'(late_cnt), 32'd255);
        chk("t6_data", rom_data, exp_word(21'h010000 + 21'(299 * 4)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
